// File: rtl/image_paste_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_paste_pkg
// Description : Shared image-pipeline definitions. Holds the sequencing state
//               encoding, the source header size, the bytes-per-pixel factor
//               and the address/coordinate widths. The cropping stage and the
//               paste stage both use it.
// Revision    : 1.0 - initial release
// ============================================================================
package image_paste_pkg;

    localparam int HDR_BYTES       = 54;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int ADDR_W          = 24;
    localparam int COORD_W         = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } paste_state_t;

endpackage
`default_nettype wire

// File: rtl/image_paste_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : img_addr_gen
// Description : Combinational address and clipping calculator for column-major
//               RGB buffers.
//   x, y, rgb      : current column, row and colour byte inside the crop
//   x_dst, y_dst   : destination corner in the full frame
//   crop_h         : crop height (rows per source column)
//   src_addr       : HDR_BYTES + (x*crop_h + y)*3 + rgb       (mod 2^24)
//   dst_addr       : (x_dst+x)*HEIGHT*3 + (y_dst+y)*3 + rgb   (mod 2^24)
//   in_frame       : destination pixel lies inside WIDTH x HEIGHT
// Revision    : 1.0 - initial release
// ============================================================================
module img_addr_gen #(
    parameter int WIDTH     = 100,
    parameter int HEIGHT    = 100,
    parameter int HDR_BYTES = image_paste_pkg::HDR_BYTES
) (
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [1:0]  rgb,
    input  logic [10:0] x_dst,
    input  logic [10:0] y_dst,
    input  logic [10:0] crop_h,
    output logic [23:0] src_addr,
    output logic [23:0] dst_addr,
    output logic        in_frame
);
    import image_paste_pkg::*;

    localparam logic [23:0] C_HDR        = 24'(HDR_BYTES);
    localparam logic [23:0] C_BPP        = 24'(BYTES_PER_PIXEL);
    localparam logic [23:0] C_COL_STRIDE = 24'(HEIGHT * BYTES_PER_PIXEL);
    localparam logic [11:0] C_WIDTH      = 12'(WIDTH);
    localparam logic [11:0] C_HEIGHT     = 12'(HEIGHT);

    logic [23:0] w_src_pix;
    logic [23:0] w_dst_col;
    logic [23:0] w_dst_row;
    logic [11:0] w_col_12;
    logic [11:0] w_row_12;

    always_comb begin
        w_src_pix = 24'(x) * 24'(crop_h) + 24'(y);
        src_addr  = C_HDR + w_src_pix * C_BPP + 24'(rgb);

        w_dst_col = 24'(x_dst) + 24'(x);
        w_dst_row = 24'(y_dst) + 24'(y);
        dst_addr  = w_dst_col * C_COL_STRIDE + w_dst_row * C_BPP + 24'(rgb);

        // One extra bit keeps corner + offset from wrapping before the compare.
        w_col_12  = {1'b0, x_dst} + {1'b0, x};
        w_row_12  = {1'b0, y_dst} + {1'b0, y};
        in_frame  = (w_col_12 < C_WIDTH) && (w_row_12 < C_HEIGHT);
    end

endmodule
`default_nettype wire

// File: rtl/image_paste.sv
`default_nettype none
// ============================================================================
// Module      : image_paste
// Description : Scatters a compact column-major cropped RGB buffer back into a
//               WIDTH x HEIGHT frame at (xDst, yDst), clipping off-frame
//               pixels. Each byte is one READ cycle then one WRITE cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   start / done        : request a paste / high while finished
//   readAddr, readdata  : source read port (1-cycle latency)
//   writeAddr, wrdata,
//   wren                : destination write port
//   xDst, yDst          : destination corner
//   cropW, cropH        : source columns / rows
// Revision    : 1.0 - initial release
// ============================================================================
module image_paste #(
    parameter int WIDTH     = 100,
    parameter int HEIGHT    = 100,
    parameter int HDR_BYTES = image_paste_pkg::HDR_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [23:0] readAddr,
    input  logic [15:0] readdata,
    output logic [23:0] writeAddr,
    output logic [15:0] wrdata,
    output logic        wren,
    input  logic [10:0] xDst,
    input  logic [10:0] yDst,
    input  logic [10:0] cropW,
    input  logic [10:0] cropH
);
    import image_paste_pkg::*;

    paste_state_t r_state, w_state_nxt;
    logic [10:0]  r_x, r_y, w_x_nxt, w_y_nxt;
    logic [1:0]   r_rgb, w_rgb_nxt;
    logic [10:0]  r_xdst, r_ydst, r_cropw, r_croph;
    logic [10:0]  w_xdst_nxt, w_ydst_nxt, w_cropw_nxt, w_croph_nxt;
    logic         w_in_frame;

    img_addr_gen #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .HDR_BYTES (HDR_BYTES)
    ) u_addr_gen (
        .x        (r_x),
        .y        (r_y),
        .rgb      (r_rgb),
        .x_dst    (r_xdst),
        .y_dst    (r_ydst),
        .crop_h   (r_croph),
        .src_addr (readAddr),
        .dst_addr (writeAddr),
        .in_frame (w_in_frame)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_rgb   <= '0;
            r_xdst  <= '0;
            r_ydst  <= '0;
            r_cropw <= '0;
            r_croph <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_rgb   <= w_rgb_nxt;
            r_xdst  <= w_xdst_nxt;
            r_ydst  <= w_ydst_nxt;
            r_cropw <= w_cropw_nxt;
            r_croph <= w_croph_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_rgb_nxt   = r_rgb;
        w_xdst_nxt  = r_xdst;
        w_ydst_nxt  = r_ydst;
        w_cropw_nxt = r_cropw;
        w_croph_nxt = r_croph;
        done        = 1'b0;
        wren        = 1'b0;
        wrdata      = '0;

        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_xdst_nxt  = xDst;
                    w_ydst_nxt  = yDst;
                    w_cropw_nxt = cropW;
                    w_croph_nxt = cropH;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_rgb_nxt   = '0;
                    w_state_nxt = (cropW == 11'd0 || cropH == 11'd0) ? DONE : READ;
                end
            end
            READ: begin
                w_state_nxt = WRITE;
            end
            WRITE: begin
                wrdata      = readdata;
                wren        = w_in_frame;
                w_state_nxt = READ;
                if (r_rgb == 2'd2) begin
                    w_rgb_nxt = 2'd0;
                    // 12-bit compares so a maximal crop size cannot wrap.
                    if (({1'b0, r_y} + 12'd1) == {1'b0, r_croph}) begin
                        w_y_nxt = '0;
                        w_x_nxt = r_x + 11'd1;
                        if (({1'b0, r_x} + 12'd1) == {1'b0, r_cropw}) begin
                            w_state_nxt = DONE;
                        end
                    end else begin
                        w_y_nxt = r_y + 11'd1;
                    end
                end else begin
                    w_rgb_nxt = r_rgb + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_image_paste.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_paste
// Description : Self-checking bench for image_paste. A behavioural model walks
//               the crop column by column and predicts, for every byte, the
//               READ-cycle source address and the WRITE-cycle strobe, address
//               and data; the source memory returns seed + (addr - 54).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_paste;

    localparam int W   = 100;
    localparam int H   = 100;
    localparam int HDR = 54;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [23:0] readAddr;
    logic [15:0] readdata;
    logic [23:0] writeAddr;
    logic [15:0] wrdata;
    logic        wren;
    logic [10:0] xDst, yDst, cropW, cropH;

    int   checks   = 0;
    int   failures = 0;
    int   seed     = 0;
    int   nwr;
    int   first_wa;
    logic prev_wren = 1'b0;

    image_paste #(.WIDTH(W), .HEIGHT(H), .HDR_BYTES(HDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .readAddr  (readAddr),
        .readdata  (readdata),
        .writeAddr (writeAddr),
        .wrdata    (wrdata),
        .wren      (wren),
        .xDst      (xDst),
        .yDst      (yDst),
        .cropW     (cropW),
        .cropH     (cropH)
    );

    always #5 clk = ~clk;

    // Source memory with one cycle of read latency.
    always @(posedge clk) readdata <= 16'(seed + int'(readAddr) - HDR);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wren) chk("wren_back_to_back", int'(prev_wren), 0);
        prev_wren = wren;
    end

    // Entered at the negedge of the first busy cycle; leaves at the negedge
    // of the cycle where done is expected.
    task automatic check_trace(input int xd, input int yd, input int w, input int h);
        int src, dst;
        bit inf;
        nwr      = 0;
        first_wa = -1;
        for (int x = 0; x < w; x++)
            for (int y = 0; y < h; y++)
                for (int c = 0; c < 3; c++) begin
                    src = HDR + (x * h + y) * 3 + c;
                    dst = (xd + x) * H * 3 + (yd + y) * 3 + c;
                    inf = (xd + x < W) && (yd + y < H);
                    chk("read_addr", int'(readAddr), src & 32'hFFFFFF);
                    chk("read_wren", int'(wren), 0);
                    chk("busy_done", int'(done), 0);
                    @(negedge clk);
                    chk("write_wren", int'(wren), int'(inf));
                    if (inf) begin
                        chk("write_addr", int'(writeAddr), dst & 32'hFFFFFF);
                        chk("write_data", int'(wrdata), (seed + src - HDR) & 32'hFFFF);
                        if (first_wa < 0) first_wa = dst;
                    end
                    nwr += int'(wren);
                    @(negedge clk);
                end
        chk("done", int'(done), 1);
    endtask

    // Pulses start for one edge, then scrambles the inputs so the DUT must
    // rely on its latched copies.
    task automatic launch(input int xd, input int yd, input int w, input int h);
        @(negedge clk);
        start = 1'b1;
        xDst  = 11'(xd);
        yDst  = 11'(yd);
        cropW = 11'(w);
        cropH = 11'(h);
        @(negedge clk);
        start = 1'b0;
        xDst  = 11'($urandom);
        yDst  = 11'($urandom);
        cropW = 11'($urandom);
        cropH = 11'($urandom);
    endtask

    typedef struct {
        int xd, yd, w, h, sd;
        int exp_nwr;
        int exp_first;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        seed = v.sd;
        launch(v.xd, v.yd, v.w, v.h);
        check_trace(v.xd, v.yd, v.w, v.h);
        chk("write_count", nwr, v.exp_nwr);
        chk("first_write_addr", first_wa, v.exp_first);
    endtask

    initial begin
        vecs[0] = '{xd: 5,  yd: 7,  w: 1, h: 1, sd: 'hA0,  exp_nwr: 3,  exp_first: 1521};
        vecs[1] = '{xd: 0,  yd: 0,  w: 2, h: 2, sd: 'h100, exp_nwr: 12, exp_first: 0};
        vecs[2] = '{xd: 99, yd: 99, w: 2, h: 2, sd: 'h200, exp_nwr: 3,  exp_first: 29997};
        vecs[3] = '{xd: 0,  yd: 0,  w: 0, h: 5, sd: 'h0,   exp_nwr: 0,  exp_first: -1};
        vecs[4] = '{xd: 98, yd: 0,  w: 3, h: 1, sd: 'h300, exp_nwr: 6,  exp_first: 29400};

        rst   = 1'b1;
        start = 1'b0;
        xDst  = '0;
        yDst  = '0;
        cropW = '0;
        cropH = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_wren", int'(wren), 0);
        chk("rst_wrdata", int'(wrdata), 0);
        chk("rst_readAddr", int'(readAddr), HDR);
        chk("rst_writeAddr", int'(writeAddr), 0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a write.
        seed = 'h400;
        launch(10, 10, 2, 2);
        @(posedge clk);
        #2;
        chk("pre_rst_wren", int'(wren), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_wren", int'(wren), 0);
        chk("async_rst_wrdata", int'(wrdata), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_readAddr", int'(readAddr), HDR);
        chk("async_rst_writeAddr", int'(writeAddr), 0);
        @(negedge clk);
        chk("rst_next_wren", int'(wren), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{xd: 10, yd: 10, w: 2, h: 2, sd: 'h500, exp_nwr: 12, exp_first: 3030});

        // start held high: busy phase ignores it, DONE restarts.
        seed = 'hA0;
        @(negedge clk);
        start = 1'b1;
        xDst  = 11'd5;
        yDst  = 11'd7;
        cropW = 11'd1;
        cropH = 11'd1;
        @(negedge clk);
        check_trace(5, 7, 1, 1);
        chk("held_first_count", nwr, 3);
        @(negedge clk);
        check_trace(5, 7, 1, 1);
        chk("held_second_count", nwr, 3);
        start = 1'b0;
        @(negedge clk);
        chk("held_done_stays", int'(done), 1);
        chk("held_done_wren", int'(wren), 0);

        // Randomised pastes, including clipped and zero-size ones.
        for (int r = 0; r < 20; r++) begin
            int xd, yd, w, h;
            xd   = int'($urandom_range(0, 110));
            yd   = int'($urandom_range(0, 110));
            w    = int'($urandom_range(0, 4));
            h    = int'($urandom_range(0, 4));
            seed = int'($urandom_range(0, 65535));
            launch(xd, yd, w, h);
            check_trace(xd, yd, w, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_paste.md
# image_paste

Writes a compact, column-major cropped RGB buffer back into a full-frame image buffer at a chosen destination corner, clipping pixels that fall outside the frame. It is the write-back counterpart of the cropping stage: it reads the byte stream that stage produces (pixel data starting after the 54-byte header region) and scatters it into the WIDTH×HEIGHT frame layout. It sits between the shared image memory's read port and its write port, and is started and sequenced by the top-level controller.

## Interface
- WIDTH, 100, destination frame width in pixels
- HEIGHT, 100, destination frame height in pixels
- HDR_BYTES, 54, byte offset of the first pixel byte in the source buffer

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a paste; sampled in IDLE and DONE only
- done  out  1  high while in DONE
- readAddr  out  24  source byte address
- readdata  in  16  source data, valid the cycle after readAddr is presented
- writeAddr  out  24  destination byte address
- wrdata  out  16  destination data
- wren  out  1  destination write strobe
- xDst, yDst  in  11 each  destination corner (column, row)
- cropW, cropH  in  11 each  source width (columns) and height (rows)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE/DONE with start=1:
  - Latch xDst, yDst, cropW and cropH.
  - Clear the counters x, y and rgb.
  - Next state is READ, or DONE if cropW=0 or cropH=0.
- Source address: HDR_BYTES + (x·cropH_l + y)·3 + rgb.
- Destination address: (xDst_l+x)·HEIGHT·3 + (yDst_l+y)·3 + rgb.
- Address arithmetic is zero-extended to 24 bits; results wrap modulo 2^24.
- READ: present readAddr, then go to WRITE.
- WRITE:
  - wrdata = readdata.
  - wren = 1 only if xDst_l+x < WIDTH and yDst_l+y < HEIGHT, compared at 12 bits so there is no overflow.
  - Clipped pixels are still read and the counters still advance, but wren stays 0.
- Counter advance at the end of WRITE:
  - rgb 0→1→2, then wraps to 0 and y increments.
  - y wraps at cropH_l and x increments.
  - When x reaches cropW_l the state goes to DONE; otherwise it goes back to READ.
- DONE: done=1; stay until start.
- start in READ or WRITE is ignored; latched parameters stay stable for the whole operation.
- readAddr and writeAddr are combinational from the latched values and counters; they are only meaningful in READ and WRITE respectively.

## Timing
- Reset values:
  - state IDLE; x, y, rgb, latched parameters all 0.
  - done=0, wren=0, wrdata=0.
  - readAddr=HDR_BYTES, writeAddr=0.
- Reset is asynchronous: asserting rst mid-operation forces the reset values immediately, the current write is abandoned, and the next write is suppressed.
- start sampled at edge N → first READ in cycle N+1, first WRITE in cycle N+2.
- Each byte takes 2 cycles; total busy time is 6·cropW·cropH cycles.
- done rises in cycle N+1+6·cropW·cropH.
- Zero-size request: done rises in cycle N+1 and no writes occur.
- wren is high for exactly one cycle per in-frame byte, never in two consecutive cycles.
- Memory read latency is fixed at 1 cycle; no wait states are supported.

## Structure
- Shared image package (used by the cropping stage and this block):
  - state enum
  - HDR_BYTES
  - BYTES_PER_PIXEL=3
  - address/coordinate width constants (24, 11)
- One natural sub-module: img_addr_gen, a combinational source/destination address and in-frame flag calculator shared with the cropping stage.
- Everything else stays in a single always_ff FSM plus one always_comb output block.

## Test plan
- 1×1 paste at (5,7), readdata = 0xA0, 0xA1, 0xA2:
  - reads 54, 55, 56;
  - writes 1521, 1522, 1523 with those values;
  - done at N+7.
- 2×2 paste at (0,0):
  - 12 writes to 0–5 and 300–305, in column order;
  - reads 54–65 sequentially;
  - done at N+25.
- 2×2 paste at (99,99): only the (99,99) pixel is written (29997–29999, 3 writes, wren=0 on the other 9 WRITE cycles); done at N+25.
- cropW=0, cropH=5: no wren, done at N+1.
- rst pulse mid-operation: outputs return to the reset values the same cycle; a new start gives a complete, correct paste.
- start held high through a 1×1 paste: the busy phase ignores it; in DONE it restarts, and a second identical write sequence follows.
